// File: rtl/regfile_init_if.sv
// Register-file bus between decode/write-back (master) and the register file (slave).
// Signals:
//   we/waddr/wdata       GPR writeback from write-back stage
//   re1/raddr1/rdata1    decode read port 1
//   re2/raddr2/rdata2    decode read port 2
//   hilo_we/hi_i/lo_i    HI/LO pair write
//   hi_o/lo_o            HI/LO read data
//   init_busy            stall request while the GPR array is being cleared
interface regfile_init_if #(
  parameter int unsigned DW = 32
);
  logic          we;
  logic [4:0]    waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [4:0]    raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [4:0]    raddr2;
  logic [DW-1:0] rdata2;
  logic          hilo_we;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          init_busy;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, hilo_we, hi_i, lo_i,
    input  rdata1, rdata2, hi_o, lo_o, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, hilo_we, hi_i, lo_i,
    output rdata1, rdata2, hi_o, lo_o, init_busy
  );
endinterface

// File: rtl/regfile_init.sv
// 32x32 GPR file plus HI/LO pair with a post-reset clear sequencer.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  regfile_init_if slave: two combinational read ports with write-first
//        bypass, one writeback port, HI/LO write/read, init_busy stall request.
// The GPR array has no reset; after rst it is zeroed one entry per cycle
// (entries 1..31, entry 0 is never read) while init_busy is held high.
module regfile_init #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  regfile_init_if.slave  bus
);
  localparam int unsigned AW = 5;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DW-1:0]   hi_q, lo_q;
  logic [DW-1:0]   mem [NREGS];
  logic            busy;
  logic            gpr_we;

  assign busy   = rst | (state_q == StInit);
  assign gpr_we = ~busy & bus.we & (bus.waddr != '0);

  // State register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      clr_ptr_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StInit: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(NREGS - 1)) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Single write port: the clear sequencer owns it during INIT, writeback in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        mem[clr_ptr_q] <= '0;
      end else if (gpr_we) begin
        mem[bus.waddr] <= bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!busy && bus.hilo_we) begin
      hi_q <= bus.hi_i;
      lo_q <= bus.lo_i;
    end
  end

  function automatic logic [DW-1:0] rd_port(input logic          busy_f,
                                            input logic          re,
                                            input logic [AW-1:0] ra,
                                            input logic          we,
                                            input logic [AW-1:0] wa,
                                            input logic [DW-1:0] wd,
                                            input logic [DW-1:0] arr);
    if (busy_f || !re || ra == '0) return '0;
    else if (we && wa == ra)       return wd;
    else                           return arr;
  endfunction

  always_comb begin
    bus.rdata1 = rd_port(busy, bus.re1, bus.raddr1, bus.we, bus.waddr, bus.wdata,
                         mem[bus.raddr1]);
    bus.rdata2 = rd_port(busy, bus.re2, bus.raddr2, bus.we, bus.waddr, bus.wdata,
                         mem[bus.raddr2]);
    bus.hi_o   = '0;
    bus.lo_o   = '0;
    if (!busy) begin
      bus.hi_o = bus.hilo_we ? bus.hi_i : hi_q;
      bus.lo_o = bus.hilo_we ? bus.lo_i : lo_q;
    end
  end

  assign bus.init_busy = busy;
endmodule

// File: tb/tb_regfile_init.sv
module tb_regfile_init;
  localparam int SelRd1  = 0;
  localparam int SelRd2  = 1;
  localparam int SelHi   = 2;
  localparam int SelLo   = 3;
  localparam int SelBusy = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_init_if #(.DW(32)) bus ();

  regfile_init #(.NREGS(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SelRd1:  act = bus.rdata1;
        SelRd2:  act = bus.rdata2;
        SelHi:   act = bus.hi_o;
        SelLo:   act = bus.lo_o;
        default: act = {31'b0, bus.init_busy};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge so new inputs settle before negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    bus.hilo_we = 0; bus.hi_i = 0; bus.lo_i = 0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    bus.we = 1; bus.waddr = a; bus.wdata = d;
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    bus.re1 = 1; bus.raddr1 = 5;
    #1;
    // Reset: two cycles with rst high
    for (int i = 0; i < 2; i++) begin
      expect_val("rst_busy", SelBusy, 32'd1);
      expect_val("rst_rd1", SelRd1, 32'd0);
      expect_val("rst_rd2", SelRd2, 32'd0);
      expect_val("rst_hi", SelHi, 32'd0);
      expect_val("rst_lo", SelLo, 32'd0);
      step();
    end
    rst = 0;
    // 31 busy cycles after rst falls
    for (int i = 0; i < 31; i++) begin
      expect_val("init_busy", SelBusy, 32'd1);
      expect_val("init_rd1", SelRd1, 32'd0);
      step();
    end
    expect_val("init_done", SelBusy, 32'd0);
    expect_val("run_rd1_r5", SelRd1, 32'd0);
    step();
    // Every register reads zero after clear
    bus.re1 = 1; bus.re2 = 1;
    for (int a = 1; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      bus.raddr2 = 5'(32 - a);
      #1;
      expect_val("clr_rd1", SelRd1, 32'd0);
      expect_val("clr_rd2", SelRd2, 32'd0);
      step();
    end

    // Write with same-cycle bypass, then from the array
    idle_inputs();
    bus.we = 1; bus.waddr = 7; bus.wdata = 32'hDEADBEEF; bus.re1 = 1; bus.raddr1 = 7;
    #1;
    expect_val("bypass_rd1", SelRd1, 32'hDEADBEEF);
    step();
    bus.we = 0;
    #1;
    expect_val("stored_rd1", SelRd1, 32'hDEADBEEF);
    step();

    // Register zero ignores writes
    idle_inputs();
    bus.we = 1; bus.waddr = 0; bus.wdata = 32'h12345678; bus.re1 = 1; bus.raddr1 = 0;
    #1;
    expect_val("r0_bypass", SelRd1, 32'd0);
    step();
    bus.we = 0;
    #1;
    expect_val("r0_stored", SelRd1, 32'd0);
    step();

    // Read enable gating
    idle_inputs();
    bus.we = 1; bus.waddr = 3; bus.wdata = 32'hA5A5A5A5; bus.re2 = 0; bus.raddr2 = 3;
    #1;
    expect_val("re2_off_bypass", SelRd2, 32'd0);
    step();
    bus.we = 0;
    #1;
    expect_val("re2_off", SelRd2, 32'd0);
    step();
    bus.re2 = 1;
    #1;
    expect_val("re2_on", SelRd2, 32'hA5A5A5A5);
    step();

    // Dual-port reads
    write_reg(4, 32'h1);
    write_reg(9, 32'h2);
    bus.re1 = 1; bus.raddr1 = 4; bus.re2 = 1; bus.raddr2 = 9;
    #1;
    expect_val("dual_rd1", SelRd1, 32'h1);
    expect_val("dual_rd2", SelRd2, 32'h2);
    step();
    bus.raddr1 = 9;
    bus.we = 1; bus.waddr = 9; bus.wdata = 32'h77;
    #1;
    expect_val("same_byp_rd1", SelRd1, 32'h77);
    expect_val("same_byp_rd2", SelRd2, 32'h77);
    step();
    bus.we = 0;
    #1;
    expect_val("same_rd1", SelRd1, 32'h77);
    expect_val("same_rd2", SelRd2, 32'h77);
    step();

    // HI/LO
    idle_inputs();
    bus.hilo_we = 1; bus.hi_i = 32'hFFFF0000; bus.lo_i = 32'h0000FFFF;
    #1;
    expect_val("hi_bypass", SelHi, 32'hFFFF0000);
    expect_val("lo_bypass", SelLo, 32'h0000FFFF);
    step();
    bus.hilo_we = 0; bus.hi_i = 32'h11111111; bus.lo_i = 32'h22222222;
    #1;
    expect_val("hi_hold", SelHi, 32'hFFFF0000);
    expect_val("lo_hold", SelLo, 32'h0000FFFF);
    step();

    // Reset clears HI/LO; then reset mid-init with blocked writes
    rst = 1;
    #1;
    expect_val("rst2_busy", SelBusy, 32'd1);
    expect_val("rst2_hi", SelHi, 32'd0);
    expect_val("rst2_lo", SelLo, 32'd0);
    step();
    rst = 0;
    bus.we = 1; bus.waddr = 2; bus.wdata = 32'h0000CAFE;
    bus.hilo_we = 1; bus.hi_i = 32'h123; bus.lo_i = 32'h456;
    bus.re1 = 1; bus.raddr1 = 2;
    #1;
    for (int i = 0; i < 15; i++) begin
      expect_val("mid_busy", SelBusy, 32'd1);
      expect_val("mid_rd1", SelRd1, 32'd0);
      expect_val("mid_hi", SelHi, 32'd0);
      step();
    end
    rst = 1;
    #1;
    expect_val("mid_rst_busy", SelBusy, 32'd1);
    step();
    rst = 0;
    #1;
    for (int i = 0; i < 31; i++) begin
      expect_val("reinit_busy", SelBusy, 32'd1);
      step();
    end
    idle_inputs();
    bus.re1 = 1; bus.raddr1 = 2; bus.re2 = 1; bus.raddr2 = 7;
    #1;
    expect_val("reinit_done", SelBusy, 32'd0);
    expect_val("blocked_r2", SelRd1, 32'd0);
    expect_val("recleared_r7", SelRd2, 32'd0);
    expect_val("blocked_hi", SelHi, 32'd0);
    expect_val("blocked_lo", SelLo, 32'd0);
    step();
    bus.raddr1 = 3; bus.raddr2 = 9;
    #1;
    expect_val("recleared_r3", SelRd1, 32'd0);
    expect_val("recleared_r9", SelRd2, 32'd0);
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
